// File: rtl/dm_pkg.sv
// Shared definitions for the dm_lane data memory.
//   - size encodings for byte / half / word accesses
//   - sweep FSM state type
//   - extend(): sign- or zero-extension of right-aligned load data
package dm_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } dm_state_e;

   // data is right-aligned; lsu=1 zero-extends, lsu=0 sign-extends.
   function automatic logic [31:0] extend(input logic [31:0] data,
                                          input logic [1:0]  size,
                                          input logic        lsu);
      logic [31:0] res;
      case (size)
         SZ_B:    res = {{24{~lsu & data[7]}}, data[7:0]};
         SZ_H:    res = {{16{~lsu & data[15]}}, data[15:0]};
         default: res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dm_lane_ram.sv
// DEPTH x 4 x 8 byte-lane RAM.
//   clk    : rising-edge clock
//   be     : per-lane write enable, lane i takes wdata[8i+7:8i]
//   waddr  : word write address
//   wdata  : write data, already replicated onto the enabled lanes
//   re     : read enable; rdata updates only when set
//   raddr  : word read address
//   rdata  : registered read data (returns pre-write contents on a same-edge write)
module dm_lane_ram #(
   parameter int unsigned DEPTH = 256
) (
   input  logic                     clk,
   input  logic [3:0]               be,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [31:0]              wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dm_lane.sv
// Byte-addressed data memory with lane-enabled stores, extended loads (latency 1),
// a post-reset zeroing sweep and sticky illegal-access reporting.
//   clk, rst          : clock, asynchronous active-high reset
//   memwrite, memread : store / load requests (ignored while ready=0)
//   size, lsu         : access size (byte/half/word), zero-extend select
//   addr, wd          : byte address, right-aligned store data
//   rd, rd_valid      : extended load data, one-cycle valid pulse per load
//   ready             : block is out of its zeroing sweep
//   err, err_cnt      : sticky illegal flag, saturating illegal count
module dm_lane
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned ADDR_W   = 32,
   parameter logic [31:0] ERR_CODE = 32'hDEAD,
   parameter int unsigned CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memwrite,
   input  logic              memread,
   input  logic [1:0]        size,
   input  logic              lsu,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wd,
   output logic [31:0]       rd,
   output logic              rd_valid,
   output logic              ready,
   output logic              err,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int unsigned WAW = $clog2(DEPTH);
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH);
   localparam logic [WAW-1:0] LAST_WORD = WAW'(DEPTH - 1);

   dm_state_e        state_q, state_d;
   logic [WAW-1:0]   init_ptr_q, init_ptr_d;
   logic             ready_q, ready_d;
   logic             ld_valid_q, ld_valid_d;
   logic             ld_err_q, ld_err_d;
   logic [1:0]       ld_lane_q, ld_lane_d;
   logic [1:0]       ld_size_q, ld_size_d;
   logic             ld_lsu_q, ld_lsu_d;
   logic [31:0]      rd_hold_q, rd_hold_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [WAW-1:0]   word;
   logic [1:0]       lane;
   logic             illegal;
   logic             rd_acc, wr_acc, err_hit;
   logic [3:0]       st_be;
   logic [31:0]      st_data;
   logic [3:0]       ram_be;
   logic [WAW-1:0]   ram_waddr;
   logic [31:0]      ram_wdata;
   logic [31:0]      ram_rdata;
   logic [31:0]      ld_data;

   // Request decode and legality.
   always_comb begin
      word    = addr[WAW+1:2];
      lane    = addr[1:0];
      illegal = (size == 2'b11)
             || ({1'b0, addr} >= ADDR_LIMIT)
             || ((size == SZ_H) && addr[0])
             || ((size == SZ_W) && (addr[1:0] != 2'b00));
      rd_acc  = ready_q & memread;
      wr_acc  = ready_q & memwrite;
      err_hit = (rd_acc | wr_acc) & illegal;
   end

   // Store lane enables; data is replicated so each enabled lane sees its slice.
   always_comb begin
      st_be   = 4'h0;
      st_data = wd;
      case (size)
         SZ_B: begin
            st_be   = 4'b0001 << lane;
            st_data = {4{wd[7:0]}};
         end
         SZ_H: begin
            st_be   = 4'b0011 << lane;
            st_data = {2{wd[15:0]}};
         end
         SZ_W:    st_be = 4'hF;
         default: st_be = 4'h0;
      endcase
   end

   // The sweep owns the write port during INIT; requests cannot reach it then.
   always_comb begin
      if (state_q == ST_INIT) begin
         ram_be    = 4'hF;
         ram_waddr = init_ptr_q;
         ram_wdata = '0;
      end else begin
         ram_be    = (wr_acc && !illegal) ? st_be : 4'h0;
         ram_waddr = word;
         ram_wdata = st_data;
      end
   end

   dm_lane_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .be    (ram_be),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (rd_acc & ~illegal),
      .raddr (word),
      .rdata (ram_rdata)
   );

   // Load alignment works on the registered RAM word plus the registered request info,
   // so rd never depends combinationally on the request inputs.
   always_comb begin
      ld_data = ld_err_q ? ERR_CODE
                         : extend(ram_rdata >> {ld_lane_q, 3'b000}, ld_size_q, ld_lsu_q);
      rd      = ld_valid_q ? ld_data : rd_hold_q;
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      unique case (state_q)
         ST_INIT: begin
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == LAST_WORD) begin
               state_d    = ST_RUN;
               init_ptr_d = '0;
            end
         end
         ST_RUN: ;
      endcase
      ready_d = (state_d == ST_RUN);

      ld_valid_d = rd_acc;
      ld_err_d   = rd_acc & illegal;
      ld_lane_d  = rd_acc ? lane : ld_lane_q;
      ld_size_d  = rd_acc ? size : ld_size_q;
      ld_lsu_d   = rd_acc ? lsu : ld_lsu_q;
      rd_hold_d  = ld_valid_q ? ld_data : rd_hold_q;

      err_d     = err_q | err_hit;
      err_cnt_d = err_cnt_q;
      if (err_hit && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
         ready_q    <= 1'b0;
         ld_valid_q <= 1'b0;
         ld_err_q   <= 1'b0;
         ld_lane_q  <= 2'b00;
         ld_size_q  <= SZ_W;
         ld_lsu_q   <= 1'b0;
         rd_hold_q  <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         ready_q    <= ready_d;
         ld_valid_q <= ld_valid_d;
         ld_err_q   <= ld_err_d;
         ld_lane_q  <= ld_lane_d;
         ld_size_q  <= ld_size_d;
         ld_lsu_q   <= ld_lsu_d;
         rd_hold_q  <= rd_hold_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign rd_valid = ld_valid_q;
   assign ready    = ready_q;
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dm_lane.sv
// Bench for dm_lane: directed scenarios plus random traffic against a byte-array model.
module tb_dm_lane;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 8;
   localparam logic [31:0] ERR    = 32'hDEAD;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              memwrite = 1'b0;
   logic              memread = 1'b0;
   logic [1:0]        size = 2'b10;
   logic              lsu = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [31:0]       wd = '0;
   logic [31:0]       rd;
   logic              rd_valid;
   logic              ready;
   logic              err;
   logic [CNT_W-1:0]  err_cnt;

   dm_lane #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ERR_CODE (ERR),
      .CNT_W    (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .memwrite (memwrite),
      .memread  (memread),
      .size     (size),
      .lsu      (lsu),
      .addr     (addr),
      .wd       (wd),
      .rd       (rd),
      .rd_valid (rd_valid),
      .ready    (ready),
      .err      (err),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [7:0]  mem_m [4*DEPTH];
   int          init_cnt;
   logic [31:0] exp_rd;
   bit          exp_valid;
   bit          exp_err;
   int          exp_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_illegal(input logic [31:0] a, input logic [1:0] s);
      if (s == 2'b11) return 1'b1;
      if (a >= 4 * DEPTH) return 1'b1;
      if (s == 2'b01 && (a % 2) != 0) return 1'b1;
      if (s == 2'b10 && (a % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int nbytes_of(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                              input logic l);
      int     n = nbytes_of(s);
      longint v = 0;
      longint half_range;
      for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mem_m[int'(a) + i]);
      half_range = longint'(1) << (8 * n - 1);
      if (!l && n < 4 && v >= half_range) v = v - 2 * half_range;
      return v[31:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4 * DEPTH; i++) mem_m[i] = 8'h00;
      init_cnt  = 0;
      exp_rd    = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_cnt   = 0;
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge.
   task automatic do_reset(input string tag);
      rst      = 1'b1;
      memread  = 1'b0;
      memwrite = 1'b0;
      #1;
      model_reset();
      check({tag, "/rst_rd_valid"}, 32'(rd_valid), 32'(exp_valid));
      check({tag, "/rst_ready"}, 32'(ready), 32'h0);
      check({tag, "/rst_err"}, 32'(err), 32'(exp_err));
      check({tag, "/rst_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
      check({tag, "/rst_rd"}, rd, exp_rd);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: apply a request, advance the model by one edge, compare all outputs.
   task automatic step(input bit mw, input bit mr, input logic [1:0] s, input bit l,
                       input logic [31:0] a, input logic [31:0] d, input string tag);
      bit rdy;
      bit ill;
      memwrite = mw;
      memread  = mr;
      size     = s;
      lsu      = l;
      addr     = a;
      wd       = d;
      @(posedge clk);
      #1;
      rdy       = (init_cnt >= DEPTH);
      ill       = is_illegal(a, s);
      exp_valid = 1'b0;
      if (rdy && mr) begin
         exp_valid = 1'b1;
         exp_rd    = ill ? ERR : model_load(a, s, l);
      end
      if (rdy && mw && !ill) begin
         for (int i = 0; i < nbytes_of(s); i++) mem_m[int'(a) + i] = d[8*i +: 8];
      end
      if (rdy && (mr || mw) && ill) begin
         exp_err = 1'b1;
         if (exp_cnt < 255) exp_cnt++;
      end
      if (init_cnt < DEPTH) init_cnt++;
      check({tag, "/ready"}, 32'(ready), 32'(init_cnt >= DEPTH));
      check({tag, "/rd_valid"}, 32'(rd_valid), 32'(exp_valid));
      check({tag, "/rd"}, rd, exp_rd);
      check({tag, "/err"}, 32'(err), 32'(exp_err));
      check({tag, "/err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 0, 2'b10, 0, 32'h0, 32'h0, tag);
   endtask

   initial begin
      #2;
      // 1) sweep length and zeroed contents
      do_reset("t1");
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 2'b10, 0, 32'h0, 32'h0, "t1_init");
         check("t1_ready_cycle", 32'(ready), 32'(i == DEPTH - 1));
      end
      step(0, 1, 2'b10, 0, 32'h0, 32'h0, "t1_lw_first");
      check("t1_lw_first_zero", rd, 32'h0);
      step(0, 1, 2'b10, 0, 32'(4 * (DEPTH - 1)), 32'h0, "t1_lw_last");
      check("t1_lw_last_zero", rd, 32'h0);

      // 2) word store, byte overwrite, word load
      step(1, 0, 2'b10, 0, 32'h10, 32'h11223344, "t2_sw");
      step(1, 0, 2'b00, 0, 32'h11, 32'h000000AA, "t2_sb");
      step(0, 1, 2'b10, 0, 32'h10, 32'h0, "t2_lw");
      check("t2_lw_data", rd, 32'h1122AA44);
      check("t2_lw_valid", 32'(rd_valid), 32'h1);
      idle(1, "t2_idle");
      check("t2_valid_pulse", 32'(rd_valid), 32'h0);

      // 3) extension
      step(1, 0, 2'b10, 0, 32'h20, 32'h000080F0, "t3_sw");
      step(0, 1, 2'b01, 0, 32'h20, 32'h0, "t3_lh_s");
      check("t3_lh_sext", rd, 32'hFFFF80F0);
      step(0, 1, 2'b01, 1, 32'h20, 32'h0, "t3_lh_z");
      check("t3_lh_zext", rd, 32'h000080F0);
      step(0, 1, 2'b00, 0, 32'h21, 32'h0, "t3_lb_s");
      check("t3_lb_sext", rd, 32'hFFFFFF80);

      // 4) illegal accesses and counter saturation
      step(0, 1, 2'b10, 0, 32'h02, 32'h0, "t4_lw_mis");
      check("t4_lw_mis_err", rd, ERR);
      step(1, 0, 2'b01, 0, 32'h03, 32'h0000BEEF, "t4_sh_mis");
      step(0, 1, 2'b10, 0, 32'h00, 32'h0, "t4_lw0_chk");
      check("t4_mem_untouched", rd, 32'h0);
      step(0, 1, 2'b10, 0, 32'(4 * DEPTH), 32'h0, "t4_lw_oob");
      check("t4_lw_oob_err", rd, ERR);
      check("t4_err", 32'(err), 32'h1);
      check("t4_err_cnt3", 32'(err_cnt), 32'd3);
      for (int i = 0; i < 300; i++) step(i % 2, 1, 2'b11, 0, 32'h0, 32'h0, "t4_sat");
      check("t4_err_cnt_sat", 32'(err_cnt), 32'd255);

      // 5) read-before-write on the same word
      step(1, 1, 2'b10, 0, 32'h10, 32'h00000005, "t5_rw");
      check("t5_old", rd, 32'h1122AA44);
      step(0, 1, 2'b10, 0, 32'h10, 32'h0, "t5_new");
      check("t5_new_data", rd, 32'h00000005);

      // random traffic after a fresh sweep
      do_reset("rnd");
      idle(DEPTH, "rnd_init");
      for (int i = 0; i < 400; i++) begin
         int unsigned op = $urandom_range(0, 3);
         step(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 4 * DEPTH + 7)), $urandom, "rnd");
      end

      // 6) reset during the sweep and with a load in flight
      do_reset("t6a");
      idle(DEPTH / 2, "t6_half");
      do_reset("t6b");
      for (int i = 0; i < DEPTH; i++) step(0, 0, 2'b10, 0, 32'h0, 32'h0, "t6_reinit");
      step(1, 0, 2'b10, 0, 32'h8, 32'h0BADF00D, "t6_sw");
      step(0, 1, 2'b11, 0, 32'h0, 32'h0, "t6_ill");
      memread = 1'b1;
      size    = 2'b10;
      addr    = 32'h8;
      @(negedge clk);
      do_reset("t6c");
      check("t6_no_valid", 32'(rd_valid), 32'h0);
      check("t6_err_clr", 32'(err), 32'h0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 2'b10, 0, 32'h0, 32'h0, "t6_reinit2");
      step(0, 1, 2'b10, 0, 32'h8, 32'h0, "t6_lw_zero");
      check("t6_lw_zeroed", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
